ir_nec_decoder: RTL

//  Sequences a restartable pulse-width timer to decode NEC IR frames from the raw, active-low IR receiver output.

---
 rtl/ir_nec_pkg.sv | 33 +++
 rtl/ir_pulse_timer.sv | 33 +++
 rtl/ir_nec_decoder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ir_nec_pkg.sv
// ir_nec_pkg: FSM state type, NEC timing multiples (in units of 562.5 us)
// and the pulse-window classification helper shared by the decoder.
package ir_nec_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEAD_MARK,
      LEAD_SPACE,
      BIT_MARK,
      BIT_SPACE,
      STOP_MARK,
      REP_MARK
   } state_t;

   localparam int unsigned LEAD_MARK_U  = 16;
   localparam int unsigned LEAD_SPACE_U = 8;
   localparam int unsigned REP_SPACE_U  = 4;
   localparam int unsigned BIT0_U       = 1;
   localparam int unsigned BIT1_U       = 3;
   localparam int unsigned TIMEOUT_U    = 20;

   // True when count lies within n*unit +/- 25 % (tolerance uses integer division).
   function automatic logic in_window(input logic [31:0] count,
                                      input int unsigned n,
                                      input int unsigned unit);
      int unsigned nom;
      int unsigned tol;
      nom = n * unit;
      tol = nom / 4;
      return (count >= nom - tol) && (count <= nom + tol);
   endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
// ir_pulse_timer: 2-FF synchroniser for the raw IR input, edge detector and
// a saturating pulse-width counter that restarts on every detected edge.
module ir_pulse_timer #(
   parameter int CNT_W = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ir_in,
   output logic             fall,
   output logic             rise,
   output logic [CNT_W-1:0] count
);

   // [0] first sync flop, [1] second sync flop, [2] previous synchronised level
   logic [2:0] sync_q;

   // Synchronise ir_in; reset to the idle-high level so release of reset makes no edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '1;
      else        sync_q <= {sync_q[1:0], ir_in};
   end

   assign fall = sync_q[2] & ~sync_q[1];
   assign rise = ~sync_q[2] & sync_q[1];

   // Elapsed cycles since the last edge, saturating at all-ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              count <= '0;
      else if (fall || rise)   count <= '0;
      else if (count != '1)    count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/ir_nec_decoder.sv
// ir_nec_decoder: NEC IR frame decoder. Classifies mark/space widths from
// ir_pulse_timer, shifts 32 bits LSB-first, checks byte complements and
// strobes address/command. Define IR_NEC_REPEAT_EN to accept repeat codes.
module ir_nec_decoder
   import ir_nec_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int          CNT_W  = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ir_in,
   output logic       data_ready,
   output logic [7:0] address,
   output logic [7:0] command,
   output logic       repeat_flag,
   output logic       frame_error,
   output logic       busy
);

   localparam int unsigned UNIT        = CLK_HZ * 9 / 16000;
   localparam int unsigned TIMEOUT_CNT = TIMEOUT_U * UNIT;

   logic             fall;
   logic             rise;
   logic             edge_any;
   logic [CNT_W-1:0] count;
   logic [31:0]      cnt32;

   logic w_lead, w_hdr, w_rep, w_bit0, w_bit1, timeout;

   state_t      state, state_next;
   logic [31:0] shift_q;
   logic [4:0]  bit_cnt;
   logic        frame_valid;

   logic bits_clr, shift_en, shift_val, stop_ok, bad_edge, tmo;
`ifdef IR_NEC_REPEAT_EN
   logic rep_ok;
   logic have_frame;
`endif

   ir_pulse_timer #(.CNT_W(CNT_W)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .ir_in (ir_in),
      .fall  (fall),
      .rise  (rise),
      .count (count)
   );

   assign cnt32    = 32'(count);
   assign edge_any = fall | rise;

   assign w_lead  = in_window(cnt32, LEAD_MARK_U,  UNIT);
   assign w_hdr   = in_window(cnt32, LEAD_SPACE_U, UNIT);
   assign w_rep   = in_window(cnt32, REP_SPACE_U,  UNIT);
   assign w_bit0  = in_window(cnt32, BIT0_U,       UNIT);
   assign w_bit1  = in_window(cnt32, BIT1_U,       UNIT);
   assign timeout = (cnt32 >= TIMEOUT_CNT);

   assign frame_valid = (shift_q[15:8]  == ~shift_q[7:0]) &&
                        (shift_q[31:24] == ~shift_q[23:16]);

   assign busy = (state != IDLE);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next state: an edge is classified first, so it wins over a same-cycle timeout.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (fall) state_next = LEAD_MARK;
         end
         LEAD_MARK: begin
            if (rise && w_lead)          state_next = LEAD_SPACE;
            else if (edge_any || timeout) state_next = IDLE;
         end
         LEAD_SPACE: begin
            if (fall && w_hdr)           state_next = BIT_MARK;
`ifdef IR_NEC_REPEAT_EN
            else if (fall && w_rep)      state_next = REP_MARK;
`endif
            else if (edge_any || timeout) state_next = IDLE;
         end
         BIT_MARK: begin
            if (rise && w_bit0)          state_next = BIT_SPACE;
            else if (edge_any || timeout) state_next = IDLE;
         end
         BIT_SPACE: begin
            if (fall && (w_bit0 || w_bit1))
               state_next = (bit_cnt == 5'd31) ? STOP_MARK : BIT_MARK;
            else if (edge_any || timeout)
               state_next = IDLE;
         end
         STOP_MARK, REP_MARK: begin
            if (edge_any || timeout) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Output decode: per-state accept/reject of the current edge and timeout.
   always_comb begin
      bits_clr  = 1'b0;
      shift_en  = 1'b0;
      shift_val = 1'b0;
      stop_ok   = 1'b0;
      bad_edge  = 1'b0;
      tmo       = 1'b0;
`ifdef IR_NEC_REPEAT_EN
      rep_ok    = 1'b0;
`endif
      if (state != IDLE && !edge_any) tmo = timeout;
      case (state)
         LEAD_MARK: bad_edge = edge_any && !(rise && w_lead);
         LEAD_SPACE: begin
            bits_clr = fall && w_hdr;
`ifdef IR_NEC_REPEAT_EN
            bad_edge = edge_any && !(fall && (w_hdr || w_rep));
`else
            // repeat-length leader space is rejected in this build
            bad_edge = edge_any && !(fall && w_hdr && !w_rep);
`endif
         end
         BIT_MARK: bad_edge = edge_any && !(rise && w_bit0);
         BIT_SPACE: begin
            shift_en  = fall && (w_bit0 || w_bit1);
            shift_val = w_bit1;
            bad_edge  = edge_any && !shift_en;
         end
         STOP_MARK: begin
            stop_ok  = rise && w_bit0;
            bad_edge = edge_any && !stop_ok;
         end
         REP_MARK: begin
`ifdef IR_NEC_REPEAT_EN
            rep_ok   = rise && w_bit0;
            bad_edge = edge_any && !rep_ok;
`else
            bad_edge = edge_any;
`endif
         end
         default: ;
      endcase
   end

   // Shift register, bit counter, held address/command and one-cycle strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q     <= '0;
         bit_cnt     <= '0;
         address     <= '0;
         command     <= '0;
         data_ready  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         data_ready  <= 1'b0;
         frame_error <= 1'b0;
         if (bits_clr) bit_cnt <= '0;
         if (shift_en) begin
            shift_q <= {shift_val, shift_q[31:1]};
            bit_cnt <= bit_cnt + 5'd1;
         end
         if (stop_ok) begin
            if (frame_valid) begin
               address    <= shift_q[7:0];
               command    <= shift_q[23:16];
               data_ready <= 1'b1;
            end else begin
               frame_error <= 1'b1;
            end
         end
`ifdef IR_NEC_REPEAT_EN
         if (rep_ok) begin
            if (have_frame) data_ready  <= 1'b1;
            else            frame_error <= 1'b1;
         end
`endif
         if (bad_edge || tmo) frame_error <= 1'b1;
      end
   end

`ifdef IR_NEC_REPEAT_EN
   // Remember a decoded frame for later repeat codes; flag strobes from repeats.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         have_frame  <= 1'b0;
         repeat_flag <= 1'b0;
      end else begin
         repeat_flag <= rep_ok && have_frame;
         if (bad_edge)                    have_frame <= 1'b0;
         else if (stop_ok && frame_valid) have_frame <= 1'b1;
      end
   end
`else
   assign repeat_flag = 1'b0;
`endif

endmodule
